// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Combinational definitions only; no latency.
// No flow control of its own.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word/word_ready are combinational on the 4th byte, so the caller can register them at that edge.
// No backpressure; the caller qualifies byte_vld with its own ready.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_ready,
    output logic [31:0] word
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0] lane;
    // The top lane is never stored: the 4th byte goes straight onto word.
    logic [23:0]       asm_q;

    assign word_ready = byte_vld && (lane == LANE_W'(BYTES_PER_WORD - 1));
    assign word       = {byte_dat, asm_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane  <= '0;
            asm_q <= '0;
        end else if (clr) begin
            lane  <= '0;
            asm_q <= '0;
        end else if (byte_vld) begin
            lane <= lane + LANE_W'(1);
            case (lane)
                2'd0:    asm_q[7:0]   <= byte_dat;
                2'd1:    asm_q[15:8]  <= byte_dat;
                2'd2:    asm_q[23:16] <= byte_dat;
                default: asm_q        <= asm_q;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a length-prefixed little-endian byte stream; holds the CPU in reset meanwhile.
// Word write (we/WA/WD) is registered at the edge that accepts the 4th byte of a word.
// in_ready decoded from state only; high in HDR0/HDR1/DATA so full-rate bytes are accepted through writes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 1024
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] WA,
    output logic [31:0]       WD,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [15:0]       hdr_len;
    logic [ADDR_W-3:0] word_idx;
    logic              xfer, restart, word_ready, last_word;
    logic [31:0]       packed_word;

    assign in_ready  = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    assign xfer      = in_valid && in_ready;
    assign restart   = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign hdr_len   = {in_data, len_q[7:0]};
    assign last_word = (32'(word_idx) + 32'd1) == 32'(len_q);

    assign cpu_hold = (state_q != DONE);
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (restart),
        .byte_vld   (xfer && (state_q == DATA)),
        .byte_dat   (in_data),
        .word_ready (word_ready),
        .word       (packed_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = HDR0;
            HDR0:            if (xfer) state_d = HDR1;
            HDR1: begin
                if (xfer) begin
                    if (hdr_len == 16'd0)                 state_d = DONE;
                    else if (32'(hdr_len) > 32'(WORDS))   state_d = ERR;
                    else                                  state_d = DATA;
                end
            end
            DATA:            if (word_ready && last_word) state_d = DONE;
            default:         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            word_idx <= '0;
            we       <= 1'b0;
            WA       <= '0;
            WD       <= '0;
        end else begin
            we <= 1'b0;
            if (restart)
                word_idx <= '0;
            if (xfer && (state_q == HDR0))
                len_q[7:0] <= in_data;
            if (xfer && (state_q == HDR1))
                len_q[15:8] <= in_data;
            // WA/WD only move on a write so they hold between strobes.
            if (word_ready) begin
                we       <= 1'b1;
                WA       <= {word_idx, 2'b00};
                WD       <= packed_word;
                word_idx <= word_idx + (ADDR_W-2)'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header decode, word packing, write strobes and reset behaviour.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [15:0] WA;
    logic [31:0] WD;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    int          we_total = 0;
    logic [15:0] wa_log[$];
    logic [31:0] wd_log[$];

    imem_loader #(.ADDR_W(16), .WORDS(1024)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .WA       (WA),
        .WD       (WD),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            we_total <= we_total + 1;
            wa_log.push_back(WA);
            wd_log.push_back(WD);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers one byte, waits (bounded) for acceptance, returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout byte=%02h in_ready=%0b required 1", b, in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({cpu_hold, in_ready, we, done, err} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got hold/rdy/we/done/err=%05b required 10000",
                         i, {cpu_hold, in_ready, we, done, err});
            end
            tick();
        end
        checks++;
        if (WA !== 16'h0 || WD !== 32'h0) begin
            errors++;
            $display("FAIL reset_wa_wd got WA=%04h WD=%08h required 0000/00000000", WA, WD);
        end
    endtask

    task automatic test_single_word();
        int base;
        base = we_total;
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL single_hdr0 got in_ready=%0b cpu_hold=%0b required 1/1", in_ready, cpu_hold);
        end
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h33, 0);
        send_byte(8'h01, 0);
        send_byte(8'h42, 0);
        send_byte(8'h00, 0);
        checks++;
        if (we !== 1'b1 || WA !== 16'h0000 || WD !== 32'h00420133) begin
            errors++;
            $display("FAIL single_write got we=%0b WA=%04h WD=%08h required 1/0000/00420133", we, WA, WD);
        end
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_done got done=%0b cpu_hold=%0b in_ready=%0b required 1/0/0",
                     done, cpu_hold, in_ready);
        end
        tick();
        tick();
        checks++;
        if (we !== 1'b0 || WD !== 32'h00420133 || (we_total - base) !== 1) begin
            errors++;
            $display("FAIL single_after got we=%0b WD=%08h writes=%0d required 0/00420133/1",
                     we, WD, we_total - base);
        end
    endtask

    task automatic test_three_words();
        int          base;
        logic [7:0]  bytes[12];
        logic [31:0] exp_wd[3];
        base = we_total;
        bytes = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                  8'h5A, 8'h5A, 8'hA5, 8'hA5};
        exp_wd = '{32'h11223344, 32'hDEADBEEF, 32'hA5A55A5A};
        pulse_start();
        send_byte(8'h03, 1);
        send_byte(8'h00, 0);
        for (int i = 0; i < 12; i++)
            send_byte(bytes[i], (i == 11) ? 0 : int'($urandom_range(0, 3)));
        repeat (3) tick();
        checks++;
        if ((we_total - base) !== 3) begin
            errors++;
            $display("FAIL three_count got writes=%0d required 3", we_total - base);
        end
        for (int i = 0; i < 3; i++) begin
            if (base + i < wa_log.size()) begin
                checks++;
                if (wa_log[base + i] !== 16'(4 * i) || wd_log[base + i] !== exp_wd[i]) begin
                    errors++;
                    $display("FAIL three_word%0d got WA=%04h WD=%08h required %04h/%08h",
                             i, wa_log[base + i], wd_log[base + i], 16'(4 * i), exp_wd[i]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL three_done got done=%0b cpu_hold=%0b required 1/0", done, cpu_hold);
        end
    endtask

    task automatic test_empty();
        int base;
        base = we_total;
        pulse_start();
        checks++;
        if (done !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL empty_restart got done=%0b cpu_hold=%0b required 0/1", done, cpu_hold);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || we !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_done got done=%0b hold=%0b we=%0b rdy=%0b required 1/0/0/0",
                     done, cpu_hold, we, in_ready);
        end
        repeat (3) tick();
        checks++;
        if ((we_total - base) !== 0) begin
            errors++;
            $display("FAIL empty_writes got writes=%0d required 0", we_total - base);
        end
    endtask

    task automatic test_oversize();
        int base;
        base = we_total;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL oversize_err got err=%0b rdy=%0b hold=%0b done=%0b required 1/0/1/0",
                     err, in_ready, cpu_hold, done);
        end
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (5) tick();
        in_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || (we_total - base) !== 0) begin
            errors++;
            $display("FAIL oversize_hold got err=%0b rdy=%0b writes=%0d required 1/0/0",
                     err, in_ready, we_total - base);
        end
        pulse_start();
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL oversize_restart got err=%0b rdy=%0b hold=%0b required 0/1/1",
                     err, in_ready, cpu_hold);
        end
    endtask

    task automatic test_reset_mid_data();
        int         base;
        logic [7:0] bytes[9];
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        do_reset();
        base = we_total;
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 9; i++) send_byte(bytes[i], 0);
        tick();
        checks++;
        if ((we_total - base) !== 2 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre got writes=%0d done=%0b required 2/0", we_total - base, done);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_hold, in_ready, we, done, err} !== 5'b10000 || WA !== 16'h0 || WD !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got hold/rdy/we/done/err=%05b WA=%04h WD=%08h required 10000/0000/00000000",
                     {cpu_hold, in_ready, we, done, err}, WA, WD);
        end
        tick();
        rst_n = 1'b1;
        tick();
        // Byte offered together with start must not be taken as a header byte.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        checks++;
        if (we !== 1'b1 || WA !== 16'h0000 || WD !== 32'h12345678 || done !== 1'b1) begin
            errors++;
            $display("FAIL mid_reload got we=%0b WA=%04h WD=%08h done=%0b required 1/0000/12345678/1",
                     we, WA, WD, done);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_single_word();
        test_three_words();
        test_empty();
        test_oversize();
        test_reset_mid_data();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory from a byte stream, the write-side counterpart of the CPU's read-only instruction fetch path. It accepts a length header and little-endian instruction bytes over a valid/ready interface, packs them into 32-bit words, and issues one word write per instruction at byte addresses 0, 4, 8, and so on. It holds the CPU in reset until a complete program has been loaded.

## Interface
Parameters:
- ADDR_W, 16: width of the byte address; matches the instruction memory address width.
- WORDS, 1024: instruction memory depth in words; maximum accepted program length.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- we  out  1  one-cycle word write strobe to the instruction memory.
- WA  out  ADDR_W  byte address of the write; always a multiple of 4 (WA[1:0] = 0).
- WD  out  32  write data.
- cpu_hold  out  1  keeps the CPU in reset while high.
- done  out  1  level; program fully written.
- err  out  1  level; header length exceeded WORDS.

## Operation
- States: IDLE, HDR0, HDR1, DATA, DONE, ERR.
- Transitions:
  - IDLE, DONE or ERR on start: go to HDR0. Clear done, err and the word counter, and raise cpu_hold.
  - HDR0, on a transfer: latch the byte as len[7:0], then go to HDR1.
  - HDR1, on a transfer: latch the byte as len[15:8], then branch on len:
    - len == 0: go to DONE.
    - len > WORDS: go to ERR.
    - otherwise: go to DATA.
  - DATA: bytes pack little-endian into a 32-bit assembly register. The first byte of a word goes to bits [7:0], the fourth to bits [31:24].
  - On the 4th byte of a word:
    - copy the assembly register into WD;
    - set WA = word_idx << 2;
    - pulse we on the following cycle;
    - increment word_idx.
  - When word_idx reaches len: go to DONE.
- in_ready is 1 in HDR0, HDR1 and DATA, and 0 in every other state. It is decoded from registered state only.
- start is ignored in HDR0, HDR1 and DATA. A load in progress cannot be restarted without reset.
- Output levels by state:
  - cpu_hold = 0 only in DONE; it is 1 in every other state, including ERR.
  - done = 1 only in DONE.
  - err = 1 only in ERR.
- Widths and arithmetic:
  - word_idx is ADDR_W-2 bits wide.
  - The byte-lane counter is 2 bits and wraps 3 -> 0 on each completed word.
  - len is 16 bits and is compared unsigned against WORDS.
- Reset mid-load: all state returns to IDLE with the reset values below. Words already written remain in memory. The partial program is never marked done.
- ERR performs no writes and accepts no bytes; only start or reset leaves it.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 0, we = 0, done = 0, err = 0.
  - WA = 0, WD = 0.
  - cpu_hold = 1.
- Write latency: the transfer of byte 4 at edge N produces we = 1 with valid WA/WD in the cycle following edge N, i.e. registered at edge N.
- WA and WD hold their values until the next write.
- in_ready stays high through write cycles, so back-to-back bytes at full rate are accepted.
- Maximum write rate is one we per 4 cycles.
- Last word: we pulses in the same cycle in which state = DONE, done = 1 and cpu_hold = 0.
- start coinciding with in_valid in IDLE: the byte is not accepted, because in_ready is still 0 in that cycle.
- in_valid may drop between bytes; stalls have no effect on the assembled data.

## Structure
- Package imem_loader_pkg contains:
  - the state enum typedef (IDLE, HDR0, HDR1, DATA, DONE, ERR);
  - the constant BYTES_PER_WORD = 4;
  - the constant HDR_BYTES = 2.
- One sub-module, word_packer: the byte-lane counter plus the 32-bit assembly register. It outputs word_ready, a pulse on the 4th byte, and the packed word. The FSM, address counter and output registers stay in imem_loader.

## Test plan
- Reset check: reset, then release with no start -> cpu_hold = 1, in_ready = 0, we = 0, done = 0 held for 20 cycles.
- Single-word load: start, then bytes 01 00 33 01 42 00 -> one we with WA = 0x0000 and WD = 0x00420133, then done = 1 and cpu_hold = 0.
- Three-word load with random in_valid gaps -> we at WA = 0, 4, 8 with correct little-endian words, and exactly 3 we pulses in total.
- Empty program: header 00 00 -> DONE directly, no we pulse.
- Oversized program: header 01 04 (len = 1025) -> err = 1, in_ready = 0, cpu_hold = 1, no we; a following start re-enters HDR0.
- Reset mid-DATA: assert rst_n low after 2 of 3 words are written -> all outputs return to reset values; a fresh start with a 1-word program writes WA = 0 and reaches DONE.
